// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with baud divider and TX FIFO
module uart_tx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_50m,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          wr_en,
  output logic                          Tx,
  output logic                          Tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Reject configurations the datapath cannot represent.
  if (DIV < 2) begin : g_bad_div
    $fatal(1, "uart_tx_param: CLK_FREQ/BAUD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $fatal(1, "uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $fatal(1, "uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "uart_tx_param: FIFO_DEPTH must be a power of 2, >= 2");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count_n;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  logic [2:0]           state, state_n;
  logic [CW-1:0]        baud_cnt, baud_cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_bit, par_bit_n;
  logic                 tx_n;
  logic                 baud_end, last_stop;

  assign push      = wr_en && !fifo_full;
  assign head      = mem[rd_ptr];
  assign baud_end  = (baud_cnt == CW'(DIV - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  // FIFO storage; reset only clears pointers, so contents need no reset.
  always_ff @(posedge clk_50m) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Occupancy after this edge; a pop and an accepted write cancel out.
  always_comb begin
    count_n = fifo_count;
    if (push && !pop)      count_n = fifo_count + 1'b1;
    else if (!push && pop) count_n = fifo_count - 1'b1;
  end

  // Frame sequencer: each state holds for DIV cycles, pops the FIFO on entry to START.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    tx_n       = Tx;
    pop        = 1'b0;
    if (state == S_IDLE) begin
      baud_cnt_n = '0;
      tx_n       = 1'b1;
      if (!fifo_empty) begin
        pop       = 1'b1;
        shreg_n   = head;
        par_bit_n = (PARITY == 1) ? ~^head : ^head;
        state_n   = S_START;
        tx_n      = 1'b0;
      end
    end else if (!baud_end) begin
      baud_cnt_n = baud_cnt + 1'b1;
    end else begin
      baud_cnt_n = '0;
      case (state)
        S_START: begin
          state_n   = S_DATA;
          bit_cnt_n = '0;
          tx_n      = shreg[0];
        end
        S_DATA: begin
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              state_n = S_PARITY;
              tx_n    = par_bit;
            end else begin
              state_n    = S_STOP;
              stop_cnt_n = 1'b0;
              tx_n       = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
          end
        end
        S_PARITY: begin
          state_n    = S_STOP;
          stop_cnt_n = 1'b0;
          tx_n       = 1'b1;
        end
        S_STOP: begin
          if (!last_stop) begin
            stop_cnt_n = stop_cnt + 1'b1;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            shreg_n   = head;
            par_bit_n = (PARITY == 1) ? ~^head : ^head;
            state_n   = S_START;
            tx_n      = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          tx_n    = 1'b1;
        end
      endcase
    end
  end

  // FIFO pointers, flags and the overflow pulse.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_n;
      fifo_full  <= (count_n == (AW+1)'(FIFO_DEPTH));
      fifo_empty <= (count_n == '0);
      overflow   <= wr_en && fifo_full;
    end
  end

  // Sequencer registers; Tx and Tx_busy come straight from flops.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      Tx       <= 1'b1;
      Tx_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_bit_n;
      Tx       <= tx_n;
      Tx_busy  <= (state_n != S_IDLE) || (count_n != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed self-checking bench for uart_tx_param
module tb_uart_tx_param;

  logic clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  int cyc = 0;
  always @(posedge clk_50m) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic rst_n;

  logic [7:0] data_a, data_b, data_c;
  logic [4:0] data_d;
  logic       wr_a, wr_b, wr_c, wr_d;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       full_a, full_b, full_c, full_d;
  logic       empty_a, empty_b, empty_c, empty_d;
  logic [4:0] count_a, count_b, count_c, count_d;
  logic       ovf_a, ovf_b, ovf_c, ovf_d;

  // 8N1, depth 16
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk_50m(clk_50m), .rst_n(rst_n), .data_in(data_a), .wr_en(wr_a), .Tx(tx_a),
    .Tx_busy(busy_a), .fifo_full(full_a), .fifo_empty(empty_a), .fifo_count(count_a),
    .overflow(ovf_a));

  // 8E1
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
    .clk_50m(clk_50m), .rst_n(rst_n), .data_in(data_b), .wr_en(wr_b), .Tx(tx_b),
    .Tx_busy(busy_b), .fifo_full(full_b), .fifo_empty(empty_b), .fifo_count(count_b),
    .overflow(ovf_b));

  // 8O2
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(16)) u_c (
    .clk_50m(clk_50m), .rst_n(rst_n), .data_in(data_c), .wr_en(wr_c), .Tx(tx_c),
    .Tx_busy(busy_c), .fifo_full(full_c), .fifo_empty(empty_c), .fifo_count(count_c),
    .overflow(ovf_c));

  // 5N1
  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(5), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(16)) u_d (
    .clk_50m(clk_50m), .rst_n(rst_n), .data_in(data_d), .wr_en(wr_d), .Tx(tx_d),
    .Tx_busy(busy_d), .fifo_full(full_d), .fifo_empty(empty_d), .fifo_count(count_d),
    .overflow(ovf_d));

  function automatic logic tx_of(input int w);
    case (w)
      0:       return tx_a;
      1:       return tx_b;
      2:       return tx_c;
      default: return tx_d;
    endcase
  endfunction

  // Advance to the falling edge that follows rising edge number t.
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_50m);
  endtask

  // Sample the line at mid-bit for nbits bits of a frame whose start bit begins at edge start.
  task automatic capture(input int w, input int start, input int nbits, output logic [15:0] v);
    v = '0;
    for (int j = 0; j < nbits; j++) begin
      wait_cyc(start + 10 * j + 5);
      v[j] = tx_of(w);
    end
  endtask

  // Single-cycle write; n returns the edge that accepts it, and we return just after it.
  task automatic push(input int w, input logic [8:0] d, output int n);
    @(negedge clk_50m);
    case (w)
      0:       begin data_a = d[7:0]; wr_a = 1'b1; end
      1:       begin data_b = d[7:0]; wr_b = 1'b1; end
      2:       begin data_c = d[7:0]; wr_c = 1'b1; end
      default: begin data_d = d[4:0]; wr_d = 1'b1; end
    endcase
    n = cyc + 1;
    @(negedge clk_50m);
    wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0; wr_d = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0; wr_d = 1'b0;
    data_a = '0; data_b = '0; data_c = '0; data_d = '0;
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    @(negedge clk_50m);
    tests++; if (tx_a !== 1'b1)     begin fails++; $display("FAIL reset_tx got %b want 1", tx_a); end
    tests++; if (busy_a !== 1'b0)   begin fails++; $display("FAIL reset_busy got %b want 0", busy_a); end
    tests++; if (full_a !== 1'b0)   begin fails++; $display("FAIL reset_full got %b want 0", full_a); end
    tests++; if (empty_a !== 1'b1)  begin fails++; $display("FAIL reset_empty got %b want 1", empty_a); end
    tests++; if (count_a !== 5'd0)  begin fails++; $display("FAIL reset_count got %0d want 0", count_a); end
    tests++; if (ovf_a !== 1'b0)    begin fails++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
    tests++; if ({tx_b, tx_c, tx_d} !== 3'b111)
      begin fails++; $display("FAIL reset_tx_bcd got %b want 111", {tx_b, tx_c, tx_d}); end
  endtask

  task automatic test_8n1();
    int n;
    logic [15:0] v;
    push(0, 9'h0A5, n);
    tests++; if (tx_a !== 1'b1)    begin fails++; $display("FAIL 8n1_tx_at_write got %b want 1", tx_a); end
    tests++; if (busy_a !== 1'b1)  begin fails++; $display("FAIL 8n1_busy_at_write got %b want 1", busy_a); end
    tests++; if (empty_a !== 1'b0) begin fails++; $display("FAIL 8n1_empty_at_write got %b want 0", empty_a); end
    tests++; if (count_a !== 5'd1) begin fails++; $display("FAIL 8n1_count_at_write got %0d want 1", count_a); end
    wait_cyc(n + 1);
    tests++; if (tx_a !== 1'b0)    begin fails++; $display("FAIL 8n1_start_latency got %b want 0", tx_a); end
    capture(0, n + 1, 10, v);
    tests++; if (v[9:0] !== 10'h34A) begin fails++; $display("FAIL 8n1_bits got %h want 34a", v[9:0]); end
    wait_cyc(n + 100);
    tests++; if (busy_a !== 1'b1)  begin fails++; $display("FAIL 8n1_busy_end got %b want 1", busy_a); end
    wait_cyc(n + 101);
    tests++; if (busy_a !== 1'b0 || tx_a !== 1'b1)
      begin fails++; $display("FAIL 8n1_idle_after got busy=%b tx=%b want 0/1", busy_a, tx_a); end
  endtask

  task automatic test_parity();
    int n;
    logic [15:0] v;
    push(1, 9'h007, n);
    capture(1, n + 1, 11, v);
    tests++; if (v[9] !== 1'b1)      begin fails++; $display("FAIL even_parity_bit got %b want 1", v[9]); end
    tests++; if (v[10:0] !== 11'h60E) begin fails++; $display("FAIL even_frame got %h want 60e", v[10:0]); end
    wait_cyc(n + 111);
    tests++; if (busy_b !== 1'b0)    begin fails++; $display("FAIL even_busy_end got %b want 0", busy_b); end

    @(negedge clk_50m);
    data_c = 8'h07; wr_c = 1'b1;
    n = cyc + 1;
    @(negedge clk_50m);
    @(negedge clk_50m);
    wr_c = 1'b0;
    capture(2, n + 1, 10, v);
    tests++; if (v[9:0] !== 10'h00E) begin fails++; $display("FAIL odd_frame got %h want 00e", v[9:0]); end
    wait_cyc(n + 100);
    tests++; if (tx_c !== 1'b0) begin fails++; $display("FAIL odd_parity_end got %b want 0", tx_c); end
    wait_cyc(n + 101);
    tests++; if (tx_c !== 1'b1) begin fails++; $display("FAIL stop2_begin got %b want 1", tx_c); end
    wait_cyc(n + 120);
    tests++; if (tx_c !== 1'b1) begin fails++; $display("FAIL stop2_end got %b want 1", tx_c); end
    wait_cyc(n + 121);
    tests++; if (tx_c !== 1'b0 || busy_c !== 1'b1)
      begin fails++; $display("FAIL stop2_next_start got tx=%b busy=%b want 0/1", tx_c, busy_c); end
    capture(2, n + 121, 12, v);
    tests++; if (v[11:0] !== 12'hC0E) begin fails++; $display("FAIL odd_frame2 got %h want c0e", v[11:0]); end
    wait_cyc(n + 241);
    tests++; if (busy_c !== 1'b0) begin fails++; $display("FAIL odd_busy_end got %b want 0", busy_c); end
  endtask

  task automatic test_fifo_burst();
    int n;
    int ovf_seen;
    int ovf_at;
    int bad_frames;
    int bad_gaps;
    ovf_seen = 0; ovf_at = -1; bad_frames = 0; bad_gaps = 0;
    @(negedge clk_50m);
    n = cyc + 1;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          data_a = 8'(i); wr_a = 1'b1;
          @(negedge clk_50m);
          if (ovf_a === 1'b1) begin ovf_seen++; ovf_at = i; end
          if (i == 16) begin
            tests++; if (full_a !== 1'b1 || count_a !== 5'd16)
              begin fails++; $display("FAIL burst_full got full=%b count=%0d want 1/16", full_a, count_a); end
          end
        end
        wr_a = 1'b0;
        @(negedge clk_50m);
        if (ovf_a === 1'b1) begin ovf_seen++; ovf_at = 18; end
        tests++; if (count_a !== 5'd16)
          begin fails++; $display("FAIL burst_dropped_count got %0d want 16", count_a); end
      end
      begin
        logic [15:0] v;
        for (int k = 0; k < 17; k++) begin
          if (k > 0) begin
            wait_cyc(n + 100 * k);
            if (tx_a !== 1'b1) bad_gaps++;
            wait_cyc(n + 100 * k + 1);
            if (tx_a !== 1'b0) bad_gaps++;
            if (k == 1) begin
              tests++; if (full_a !== 1'b0 || count_a !== 5'd15)
                begin fails++; $display("FAIL burst_drain got full=%b count=%0d want 0/15", full_a, count_a); end
            end
          end
          capture(0, n + 1 + 100 * k, 10, v);
          if (v[9:0] !== {1'b1, k[7:0], 1'b0}) begin
            bad_frames++;
            $display("FAIL burst_frame%0d got %h want %h", k, v[9:0], {1'b1, k[7:0], 1'b0});
          end
        end
      end
    join
    tests++; if (ovf_seen != 1 || ovf_at != 17)
      begin fails++; $display("FAIL burst_overflow got pulses=%0d at=%0d want 1 at 17", ovf_seen, ovf_at); end
    tests++; if (bad_frames != 0) begin fails++; $display("FAIL burst_frames got %0d bad want 0", bad_frames); end
    tests++; if (bad_gaps != 0)   begin fails++; $display("FAIL burst_gaps got %0d bad want 0", bad_gaps); end
    wait_cyc(n + 1700);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL burst_busy_tail got %b want 1", busy_a); end
    wait_cyc(n + 1701);
    tests++; if (busy_a !== 1'b0 || empty_a !== 1'b1)
      begin fails++; $display("FAIL burst_done got busy=%b empty=%b want 0/1", busy_a, empty_a); end
  endtask

  task automatic test_reset_midframe();
    int n;
    int bad;
    bad = 0;
    @(negedge clk_50m);
    n = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      data_a = 8'h00; wr_a = 1'b1;
      @(negedge clk_50m);
    end
    wr_a = 1'b0;
    tests++; if (count_a !== 5'd3) begin fails++; $display("FAIL midrst_queued got %0d want 3", count_a); end
    wait_cyc(n + 35);
    tests++; if (tx_a !== 1'b0) begin fails++; $display("FAIL midrst_pre_tx got %b want 0", tx_a); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (tx_a !== 1'b1 || busy_a !== 1'b0)
      begin fails++; $display("FAIL midrst_async got tx=%b busy=%b want 1/0", tx_a, busy_a); end
    tests++; if (empty_a !== 1'b1 || count_a !== 5'd0)
      begin fails++; $display("FAIL midrst_fifo got empty=%b count=%0d want 1/0", empty_a, count_a); end
    @(negedge clk_50m);
    @(negedge clk_50m);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50m);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || empty_a !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midrst_silent got %0d active cycles want 0", bad); end
  endtask

  task automatic test_5bit();
    int n;
    logic [15:0] v;
    push(3, 9'h013, n);
    tests++; if (tx_d !== 1'b1) begin fails++; $display("FAIL 5bit_tx_at_write got %b want 1", tx_d); end
    capture(3, n + 1, 7, v);
    tests++; if (v[6:0] !== 7'h66) begin fails++; $display("FAIL 5bit_bits got %h want 66", v[6:0]); end
    wait_cyc(n + 70);
    tests++; if (busy_d !== 1'b1 || tx_d !== 1'b1)
      begin fails++; $display("FAIL 5bit_stop got busy=%b tx=%b want 1/1", busy_d, tx_d); end
    wait_cyc(n + 71);
    tests++; if (busy_d !== 1'b0) begin fails++; $display("FAIL 5bit_len got busy=%b want 0", busy_d); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_fifo_burst();
    test_reset_midframe();
    test_5bit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
